// File: rtl/ahb5_slv_pkg.sv
// Shared encodings and the byte-lane strobe helper for the AHB5 slave memory.
package ahb5_slv_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  // One strobe bit per byte lane touched by a transfer of 2**size bytes at lane offset off.
  function automatic logic [7:0] lane_strb(input logic [2:0] off, input logic [2:0] size);
    logic [15:0] m;
    m = ((16'd1 << (5'd1 << size)) - 16'd1) << off;
    return m[7:0];
  endfunction
endpackage

// File: rtl/ahb5_slv_excl_mon.sv
// Single-entry exclusive reservation {valid, master, word}; updated when a data phase ends.
module ahb5_slv_excl_mon #(
  parameter int IW = 10
)(
  input  logic          Hclk,
  input  logic          HRESET,
  input  logic          xfer_end,
  input  logic          wr,
  input  logic          excl,
  input  logic          commit,
  input  logic [3:0]    master,
  input  logic [IW-1:0] idx,
  output logic          match
);
  logic          rv;
  logic [3:0]    rm;
  logic [IW-1:0] ri;

  assign match = rv && (rm == master) && (ri == idx);

  always_ff @(posedge Hclk or posedge HRESET) begin
    if (HRESET) begin
      rv <= 1'b0;
      rm <= '0;
      ri <= '0;
    end else if (xfer_end) begin
      if (excl && !wr) begin
        rv <= 1'b1;
        rm <= master;
        ri <= idx;
      end else if (wr && commit && (ri == idx) && (excl || (rm != master))) begin
        // successful exclusive store consumes it; another master's store breaks it
        rv <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/ahb5_slave_mem.sv
// AHB5 slave memory: byte-strobed word array, WAIT_STATES read/write latency, two-cycle ERROR.
// Define AHB5_SLV_EXCL_EN to add the exclusive monitor and the Hexcl/Hmaster/Hexokay ports.
module ahb5_slave_mem
  import ahb5_slv_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
)(
  input  logic              Hclk,
  input  logic              HRESET,
  input  logic              Hselx,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic              Hwrite,
  input  logic [2:0]        Hburst,
  input  logic [3:0]        Hprot,
  input  logic [1:0]        Htrans,
  input  logic              Hmastlock,
  input  logic [2:0]        Hsize,
  input  logic              Hready,
  input  logic [DATA_W-1:0] Hwdata,
`ifdef AHB5_SLV_EXCL_EN
  input  logic              Hexcl,
  input  logic [3:0]        Hmaster,
  output logic              Hexokay,
`endif
  output logic              Hreadyout,
  output logic              Hresp,
  output logic [DATA_W-1:0] Hrdata
);
  localparam int NB = DATA_W / 8;
  localparam int BW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH * NB);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [2:0]    state;
  logic [3:0]    wcnt;
  logic          d_write, d_excl;
  logic [IW-1:0] d_idx;
  logic [NB-1:0] d_strb;

  logic          acc, a_bad, a_excl, ex_match, dend, wr_commit;
  logic [7:0]    a_lanes;
  logic [NB-1:0] a_strb;
  logic [IW-1:0] a_idx, rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic          unused_ok;

  assign Hreadyout = !(state == ST_WAIT || state == ST_ERR1);
  assign Hresp     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

  assign acc     = Hselx && Hready && Htrans[1] && Hreadyout;
  assign a_bad   = ({1'b0, Haddr} >= LIM) || (Hsize > 3'(BW)) ||
                   (|(Haddr[2:0] & ((3'b1 << Hsize) - 3'b1)));
  assign a_lanes = lane_strb(3'(Haddr[BW-1:0]), Hsize);
  assign a_strb  = a_lanes[NB-1:0];
  assign a_idx   = Haddr[BW +: IW];
  assign unused_ok = &{1'b0, Hburst, Hprot, Hmastlock, Htrans[0], a_lanes};

  assign dend      = (state == ST_DATA);
  assign wr_commit = dend && d_write && (!d_excl || ex_match);

  // Read word with the in-flight write merged in, so a read right behind a write sees it.
  assign rd_idx = (state == ST_WAIT) ? d_idx : a_idx;
  always_comb begin
    rd_word = mem[rd_idx];
    for (int b = 0; b < NB; b++)
      if (wr_commit && d_strb[b] && (d_idx == rd_idx)) rd_word[8*b +: 8] = Hwdata[8*b +: 8];
  end

  always_ff @(posedge Hclk) begin
    if (wr_commit)
      for (int b = 0; b < NB; b++)
        if (d_strb[b]) mem[d_idx][8*b +: 8] <= Hwdata[8*b +: 8];
  end

  always_ff @(posedge Hclk or posedge HRESET) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      wcnt    <= '0;
      d_write <= 1'b0;
      d_excl  <= 1'b0;
      d_idx   <= '0;
      d_strb  <= '0;
      Hrdata  <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (wcnt == 4'd1) begin
            state <= ST_DATA;
            if (!d_write) Hrdata <= rd_word;
          end
        end
        ST_ERR1: state <= ST_ERR2;
        default: begin
          if (acc) begin
            d_write <= Hwrite;
            d_excl  <= a_excl;
            d_idx   <= a_idx;
            d_strb  <= a_strb;
            if (a_bad) begin
              state <= ST_ERR1;
            end else if (WAIT_STATES > 0) begin
              state <= ST_WAIT;
              wcnt  <= 4'(WAIT_STATES);
            end else begin
              state <= ST_DATA;
              if (!Hwrite) Hrdata <= rd_word;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef AHB5_SLV_EXCL_EN
  logic [3:0] d_master;

  assign a_excl  = Hexcl;
  assign Hexokay = dend && d_excl && (!d_write || ex_match);

  always_ff @(posedge Hclk or posedge HRESET) begin
    if (HRESET)   d_master <= '0;
    else if (acc) d_master <= Hmaster;
  end

  ahb5_slv_excl_mon #(.IW(IW)) u_excl (
    .Hclk     (Hclk),
    .HRESET   (HRESET),
    .xfer_end (dend),
    .wr       (d_write),
    .excl     (d_excl),
    .commit   (wr_commit),
    .master   (d_master),
    .idx      (d_idx),
    .match    (ex_match)
  );
`else
  assign a_excl   = 1'b0;
  assign ex_match = 1'b0;
`endif
endmodule

// File: tb/tb_ahb5_slave_mem.sv
// Scoreboard bench: two slaves (0 and 3 wait states) share the bus, a transfer-level model predicts responses.
module tb_ahb5_slave_mem;
  localparam int DEPTH = 1024;

  logic        Hclk = 1'b0;
  logic        HRESET = 1'b1;
  logic        hsel0 = 1'b0, hsel3 = 1'b0;
  logic [31:0] Haddr = '0, Hwdata = '0;
  logic        Hwrite = 1'b0, Hmastlock = 1'b0, Hexcl = 1'b0;
  logic [1:0]  Htrans = 2'b00;
  logic [2:0]  Hsize = 3'd2, Hburst = 3'd0;
  logic [3:0]  Hprot = 4'd0, Hmaster = 4'd0;
  logic        rdy0, rdy3, resp0, resp3, xok0, xok3;
  logic [31:0] rd0, rd3;

  always #5 Hclk = ~Hclk;

  ahb5_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .Hclk(Hclk), .HRESET(HRESET), .Hselx(hsel0), .Haddr(Haddr), .Hwrite(Hwrite),
    .Hburst(Hburst), .Hprot(Hprot), .Htrans(Htrans), .Hmastlock(Hmastlock), .Hsize(Hsize),
    .Hready(rdy0), .Hwdata(Hwdata),
`ifdef AHB5_SLV_EXCL_EN
    .Hexcl(Hexcl), .Hmaster(Hmaster), .Hexokay(xok0),
`endif
    .Hreadyout(rdy0), .Hresp(resp0), .Hrdata(rd0));

  ahb5_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .Hclk(Hclk), .HRESET(HRESET), .Hselx(hsel3), .Haddr(Haddr), .Hwrite(Hwrite),
    .Hburst(Hburst), .Hprot(Hprot), .Htrans(Htrans), .Hmastlock(Hmastlock), .Hsize(Hsize),
    .Hready(rdy3), .Hwdata(Hwdata),
`ifdef AHB5_SLV_EXCL_EN
    .Hexcl(Hexcl), .Hmaster(Hmaster), .Hexokay(xok3),
`endif
    .Hreadyout(rdy3), .Hresp(resp3), .Hrdata(rd3));

`ifndef AHB5_SLV_EXCL_EN
  assign xok0 = 1'b0;
  assign xok3 = 1'b0;
`endif

  typedef struct { bit wr; bit [31:0] addr; bit [2:0] size; bit [31:0] data; bit excl; bit [3:0] mst; } tx_t;
  typedef struct { bit err; bit [31:0] rdata; bit xok; int waits; } exp_t;

  tx_t  txq[$];
  exp_t expq[$];
  int   checks = 0, errors = 0;
  int   tsel = 0;       // 0 -> dut0, 1 -> dut3
  bit   mon_en = 1'b0;

  // reference model: memory words, last returned read data, reservation
  bit [31:0] mdl [2][DEPTH];
  bit [31:0] lastrd [2];
  bit        rv [2];
  bit [3:0]  rm [2];
  int        rw [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic issue(input bit wr, input bit [31:0] addr, input bit [2:0] size,
                       input bit [31:0] data, input bit excl, input bit [3:0] mst);
    tx_t t; exp_t e; int w, off, n; bit ok;
    t.wr = wr; t.addr = addr; t.size = size; t.data = data; t.excl = excl; t.mst = mst;
    txq.push_back(t);
    w = int'(addr >> 2); off = int'(addr % 4); n = 1 << size;
    e.err = 0; e.rdata = lastrd[tsel]; e.xok = 0; e.waits = (tsel == 1) ? 3 : 0;
    if (addr >= DEPTH*4 || size > 2 || (addr % n) != 0) begin
      e.err = 1; e.waits = 1;
    end else if (!wr) begin
      e.rdata = mdl[tsel][w];
      lastrd[tsel] = e.rdata;
      if (excl) begin rv[tsel] = 1; rm[tsel] = mst; rw[tsel] = w; e.xok = 1; end
    end else begin
      ok = !excl || (rv[tsel] && rm[tsel] == mst && rw[tsel] == w);
      if (ok) begin
        for (int b = off; b < off + n; b++) mdl[tsel][w][8*b +: 8] = data[8*b +: 8];
        if (rv[tsel] && rw[tsel] == w && (excl || rm[tsel] != mst)) rv[tsel] = 0;
        e.xok = excl;
      end
    end
    expq.push_back(e);
  endtask

  // Pipelined master: address phase of the next transfer overlaps the current data phase.
  task automatic run();
    tx_t a, d; bit have_a, have_d, prev; int guard;
    have_a = 0; have_d = 0; prev = 1; guard = 0;
    while ((txq.size() > 0 || have_a || have_d) && guard < 5000) begin
      @(negedge Hclk); #1;
      if (prev) begin
        have_d = have_a; d = a;
        have_a = (txq.size() > 0);
        if (have_a) a = txq.pop_front();
      end
      hsel0   = have_a && tsel == 0;
      hsel3   = have_a && tsel == 1;
      Htrans  = have_a ? 2'b10 : 2'b00;
      Haddr   = a.addr; Hwrite = a.wr; Hsize = a.size; Hexcl = a.excl; Hmaster = a.mst;
      Hwdata  = have_d ? d.data : 32'h0;
      prev    = (tsel == 1) ? rdy3 : rdy0;
      guard++;
    end
    if (guard >= 5000) chk("driver_timeout", 1, 0);
    @(negedge Hclk); #1;
    hsel0 = 0; hsel3 = 0; Htrans = 2'b00;
    repeat (2) @(negedge Hclk);
  endtask

  task automatic init_words();
    for (int i = 0; i < 32; i++) issue(1, 32'(i*4), 2, $urandom, 0, 1);
  endtask

  task automatic rand_batch(input int n);
    for (int i = 0; i < n; i++) begin
      int k; bit [2:0] s; bit [31:0] a; bit ex; bit [3:0] m;
      k = $urandom_range(0, 99);
      ex = 0; m = 1;
`ifdef AHB5_SLV_EXCL_EN
      ex = ($urandom_range(0, 3) == 0); m = 4'($urandom_range(1, 3));
`endif
      s = 3'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 31)) * 4 + (32'($urandom_range(0, 3)) & ~((32'd1 << s) - 1));
      if (k < 4)      a = a + DEPTH*4 + 32'($urandom_range(0, 255)) * 4;
      else if (k < 7) begin s = 3'($urandom_range(1, 2)); a = a | 32'd1; end
      else if (k < 9) begin s = 3'd3; a = a & ~32'd7; end
      issue($urandom_range(0, 1) == 1, a, s, $urandom, ex, m);
    end
  endtask

  // Monitor: samples mid-cycle, pops one expectation per completed data phase.
  initial begin
    bit in_dp; int waits; exp_t e; logic r, rs, xk, sl; logic [31:0] rd;
    in_dp = 0; waits = 0;
    forever begin
      @(negedge Hclk); #2;
      if (HRESET || !mon_en) begin in_dp = 0; waits = 0; continue; end
      r  = (tsel == 1) ? rdy3 : rdy0;
      rs = (tsel == 1) ? resp3 : resp0;
      rd = (tsel == 1) ? rd3 : rd0;
      xk = (tsel == 1) ? xok3 : xok0;
      sl = (tsel == 1) ? hsel3 : hsel0;
      if (in_dp) begin
        if (expq.size() == 0) begin
          chk("unexpected_data_phase", 1, 0); in_dp = 0;
        end else if (!r) begin
          waits++;
          chk("resp_in_wait", rs, expq[0].err);
`ifdef AHB5_SLV_EXCL_EN
          chk("exokay_in_wait", xk, 0);
`endif
          if (waits > 30) begin chk("wait_timeout", waits, expq[0].waits); void'(expq.pop_front()); in_dp = 0; waits = 0; end
        end else begin
          e = expq.pop_front();
          chk("wait_cycles", waits, e.waits);
          chk("resp_final", rs, e.err);
          if (!e.err) chk("rdata", rd, e.rdata);
`ifdef AHB5_SLV_EXCL_EN
          chk("exokay", xk, e.xok);
`endif
          waits = 0;
        end
      end
      if (r) in_dp = sl && Htrans[1];
    end
  end

  initial begin
    rv = '{0, 0}; lastrd = '{0, 0}; rm = '{0, 0}; rw = '{0, 0};
    #2;
    chk("rst_rdy0", rdy0, 1); chk("rst_resp0", resp0, 0); chk("rst_rdata0", rd0, 0);
    chk("rst_rdy3", rdy3, 1); chk("rst_resp3", resp3, 0); chk("rst_rdata3", rd3, 0);
`ifdef AHB5_SLV_EXCL_EN
    chk("rst_xok0", xok0, 0); chk("rst_xok3", xok3, 0);
`endif
    @(negedge Hclk); #1; HRESET = 0; mon_en = 1;

    // zero-wait slave: directed cases then random traffic
    tsel = 0;
    init_words();
    issue(1, 32'h10, 2, 32'hDEADBEEF, 0, 1);
    issue(0, 32'h10, 2, 0, 0, 1);
    issue(1, 32'h10, 2, 32'h11223344, 0, 1);
    issue(1, 32'h13, 0, 32'hAA000000, 0, 1);
    issue(0, 32'h10, 2, 0, 0, 1);
    issue(0, 32'(DEPTH*4), 2, 0, 0, 1);
    issue(1, 32'h1, 1, 32'hFFFFFFFF, 0, 1);
    issue(0, 32'h0, 2, 0, 0, 1);
    issue(1, 32'h20, 2, 32'hCAFEF00D, 0, 1);
    issue(0, 32'h20, 2, 0, 0, 1);
`ifdef AHB5_SLV_EXCL_EN
    issue(0, 32'h40, 2, 0, 1, 1);
    issue(1, 32'h40, 2, 32'h5555AAAA, 1, 1);
    issue(0, 32'h40, 2, 0, 0, 1);
    issue(0, 32'h40, 2, 0, 1, 1);
    issue(1, 32'h40, 2, 32'h12345678, 0, 2);
    issue(1, 32'h40, 2, 32'h99999999, 1, 1);
    issue(0, 32'h40, 2, 0, 0, 1);
`endif
    rand_batch(150);
    run();

    // three-wait-state slave
    tsel = 1;
    init_words();
    issue(0, 32'h14, 2, 0, 0, 1);
    issue(1, 32'h17, 0, 32'h5A000000, 0, 1);
    issue(0, 32'h14, 2, 0, 0, 1);
    issue(1, 32'(DEPTH*4), 2, 32'h1, 0, 1);
    rand_batch(80);
    run();

    // reset in the middle of a wait-stated write drops it
    mon_en = 0;
    @(negedge Hclk); #1;
    hsel3 = 1; Htrans = 2'b10; Hwrite = 1; Haddr = 32'h14; Hsize = 2; Hexcl = 0;
    @(negedge Hclk); #1;
    hsel3 = 0; Htrans = 2'b00; Hwdata = 32'hFFFFFFFF;
    chk("wait_before_reset", rdy3, 0);
    HRESET = 1; #1;
    chk("async_rst_rdy", rdy3, 1); chk("async_rst_resp", resp3, 0); chk("async_rst_rdata", rd3, 0);
    @(negedge Hclk); #1; HRESET = 0;
    rv = '{0, 0}; lastrd = '{0, 0};
    mon_en = 1;
    issue(0, 32'h14, 2, 0, 0, 1);
    issue(0, 32'h10, 2, 0, 0, 1);
    run();

    chk("scoreboard_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/ahb5_slave_mem.md
# ahb5_slave_mem

Parametrised AHB5 slave memory: the next-generation synthesizable slave behind the AHB5 slave VIP, driven by the same bus signal set. It decodes address-phase controls, stores write data in an internal word array with byte-lane strobing, returns read data with a configurable number of wait states, and raises the two-cycle ERROR response on illegal accesses. An optional exclusive-access monitor provides the AHB5 HEXCL/HEXOKAY handshake.

## Interface
- ADDR_W, 32: Haddr width in bits.
- DATA_W, 32: Hwdata/Hrdata width in bits; legal values 32 or 64.
- DEPTH, 1024: number of DATA_W-bit words; byte address range is 0 .. DEPTH*DATA_W/8-1.
- WAIT_STATES, 0: extra cycles of Hreadyout=0 inserted per accepted OKAY transfer; legal range 0..15.
- Hclk  in  1  bus clock; all state changes on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- Hselx  in  1  slave select.
- Haddr  in  ADDR_W  byte address.
- Hwrite  in  1  1 = write.
- Hburst  in  3  burst type; sampled but not used, because the master supplies every beat address.
- Hprot  in  4  protection; ignored.
- Htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- Hmastlock  in  1  ignored.
- Hsize  in  3  transfer size as log2(bytes).
- Hready  in  1  bus-level ready from the interconnect.
- Hwdata  in  DATA_W  write data; valid in the data phase.
- Hreadyout  out  1  slave ready.
- Hresp  out  1  0 = OKAY, 1 = ERROR.
- Hrdata  out  DATA_W  read data.
- Hexcl  in  1  exclusive transfer; present only with the macro.
- Hmaster  in  4  master ID; present only with the macro.
- Hexokay  out  1  exclusive success; present only with the macro.

## Operation
- Address phase accepted when Hselx & Hready & Htrans[1] are all 1. IDLE or BUSY, or an unselected cycle, produces a zero-wait OKAY.
- Illegal access, which causes an ERROR response and no memory change:
  - address beyond the range;
  - Hsize > log2(DATA_W/8);
  - Haddr not aligned to Hsize.
- State machine:
  - IDLE → WAIT when an access is accepted with WAIT_STATES>0. The counter loads WAIT_STATES and decrements to 0.
  - IDLE → DATA when WAIT_STATES=0.
  - WAIT → DATA when the counter reaches 0.
  - Accepted illegal access → ERR1 → ERR2.
  - DATA or ERR2 → next accepted access, or IDLE.
- Writes: byte lanes are decoded from Haddr[log2(DATA_W/8)-1:0] and Hsize. Lanes commit at the edge that ends the data phase (Hreadyout=1).
- Reads: the word is fetched from the array and registered. Hrdata is valid in the final data-phase cycle and holds its value until the next read completes.
- Write-to-read bypass: if a read address phase coincides with the data phase of a write to the same word, the returned data is the merged new data.
- The full data word is returned for narrow reads; no lane masking.

## Timing
- Reset values: Hreadyout=1, Hresp=0, Hrdata=0, Hexokay=0, state IDLE, reservation invalid. Memory contents are not reset.
- OKAY transfer: data phase lasts 1+WAIT_STATES cycles, with Hreadyout=0 for the first WAIT_STATES cycles.
- ERROR response:
  - ERR1: Hresp=1, Hreadyout=0.
  - ERR2: Hresp=1, Hreadyout=1.
  - WAIT_STATES is not applied to ERROR.
- Back-to-back pipelined NONSEQ/SEQ at WAIT_STATES=0 sustains one transfer per cycle.
- HRESET asserted mid-transfer aborts it immediately: a pending write is dropped and outputs return to reset values asynchronously.

## Configuration
- AHB5_SLV_EXCL_EN defined:
  - Single-entry reservation {valid, master, word address}.
  - Exclusive read: sets the reservation; Hexokay=1 in its final data cycle.
  - Exclusive write: if the reservation matches master and word, the write commits, Hexokay=1 and the reservation clears. Otherwise the write is suppressed with Hresp=OKAY and Hexokay=0.
  - Any committed write to the reserved word from a different master clears the reservation.
  - Hexokay is 0 whenever Hreadyout=0 or Hresp=1.
- AHB5_SLV_EXCL_EN undefined: Hexcl, Hmaster and Hexokay are absent, and every legal write commits.

## Structure
- Package ahb5_slv_pkg:
  - Htrans and Hsize encodings;
  - HRESP_OKAY and HRESP_ERROR;
  - state enum {IDLE, WAIT, DATA, ERR1, ERR2};
  - lane-strobe function.
- Sub-module ahb5_slv_excl_mon holds the reservation logic and is instantiated only under the macro.

## Test plan
- Write 0xDEADBEEF to 0x10 at WAIT_STATES=0, then read 0x10 → Hrdata=0xDEADBEEF, Hresp=0, no wait cycles.
- Byte write 0xAA to 0x13 over word 0x11223344, then read 0x10 → 0xAA223344 (DATA_W=32, little-endian).
- WAIT_STATES=3 read → Hreadyout low for exactly 3 cycles, then data valid.
- Access to address DEPTH*4, or a halfword at 0x1 → ERR1/ERR2 sequence (Hresp=1 for 2 cycles), and memory unchanged.
- Pipelined write to 0x20 followed immediately by a read of 0x20 → new data returned via the bypass.
- Under the macro:
  - Master 1 exclusive read then exclusive write to 0x40 → Hexokay=1 and the write commits.
  - Same sequence with a master 2 write to 0x40 in between → Hexokay=0 and master 2's data is retained.
